// File: rtl/sram_req_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one SRAM-like port.
// Data wins ties, a stalled winner stays locked, and an owner FIFO routes in-order responses.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             lock_q, lock_d;
  logic             lock_owner_q, lock_owner_d;
  logic [DEPTH-1:0] own_q, own_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic owner_req;
  logic grant_data;
  logic grant_req;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_owner;

  // A held lock only counts while its owner still requests, so a dropped owner
  // releases the port in the same cycle instead of wasting one.
  always_comb begin
    owner_req  = lock_owner_q ? data_req : inst_req;
    grant_data = data_req;
    if (lock_q && owner_req) begin
      grant_data = lock_owner_q;
    end
    grant_req = grant_data ? data_req : inst_req;
  end

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_owner = own_q[rd_ptr_q];

  always_comb begin
    mem_req   = grant_req & ~fifo_full;
    mem_wr    = 1'b0;
    mem_size  = inst_size;
    mem_wstrb = 4'h0;
    mem_addr  = inst_addr;
    mem_wdata = 32'h0;
    if (grant_data) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign push = mem_req & mem_addr_ok;
  assign pop  = mem_data_ok & ~fifo_empty;

  assign inst_addr_ok = push & ~grant_data;
  assign data_addr_ok = push &  grant_data;
  assign inst_data_ok = pop  & ~head_owner;
  assign data_data_ok = pop  &  head_owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    lock_d       = 1'b0;
    lock_owner_d = lock_owner_q;
    own_d        = own_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    // Remember who was presented but stalled so the request cannot be swapped mid-handshake.
    if (mem_req && !mem_addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = grant_data;
    end

    if (push) begin
      own_d[wr_ptr_q] = grant_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      own_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      own_q        <= own_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed, self-checking bench for sram_req_arbiter (DEPTH = 4).
module tb_sram_req_arbiter;

  localparam logic [31:0] IADDR = 32'h1000_0040;
  localparam logic [31:0] DADDR = 32'h2000_0080;
  localparam logic [31:0] WDATA = 32'h5555_AAAA;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int errors;
  int checks;

  sram_req_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic ir, input logic dr, input logic aok,
                               input logic dok, input logic [31:0] rd);
    @(negedge clk);
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic acceptOne(input logic is_data);
    applyStimulus(~is_data, is_data, 1'b1, 1'b0, 32'h0);
    checkOutput("accept_inst_ok", {31'b0, inst_addr_ok}, {31'b0, ~is_data});
    checkOutput("accept_data_ok", {31'b0, data_addr_ok}, {31'b0, is_data});
  endtask

  task automatic returnOne(input logic is_data, input logic [31:0] rd);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, rd);
    checkOutput("ret_inst_data_ok", {31'b0, inst_data_ok}, {31'b0, ~is_data});
    checkOutput("ret_data_data_ok", {31'b0, data_data_ok}, {31'b0, is_data});
    checkOutput("ret_rdata", is_data ? data_rdata : inst_rdata, rd);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    inst_req    = 1'b0;
    inst_size   = 2'd2;
    inst_addr   = IADDR;
    data_req    = 1'b0;
    data_wr     = 1'b1;
    data_size   = 2'd2;
    data_wstrb  = 4'hC;
    data_addr   = DADDR;
    data_wdata  = WDATA;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
    checkOutput("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);

    // Simultaneous requests: data wins, inst follows next cycle
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("prio_data_ok", {31'b0, data_addr_ok}, 32'd1);
    checkOutput("prio_inst_ok", {31'b0, inst_addr_ok}, 32'd0);
    checkOutput("prio_addr", mem_addr, DADDR);
    checkOutput("prio_wr", {31'b0, mem_wr}, 32'd1);
    checkOutput("prio_wstrb", {28'b0, mem_wstrb}, 32'hC);
    checkOutput("prio_wdata", mem_wdata, WDATA);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("next_inst_ok", {31'b0, inst_addr_ok}, 32'd1);
    checkOutput("next_addr", mem_addr, IADDR);
    checkOutput("inst_forced_wr", {31'b0, mem_wr}, 32'd0);
    checkOutput("inst_forced_wstrb", {28'b0, mem_wstrb}, 32'd0);
    checkOutput("inst_forced_wdata", mem_wdata, 32'd0);
    returnOne(1'b1, 32'h0000_00AA);
    returnOne(1'b0, 32'h0000_00BB);

    // Stalled inst keeps the grant while data arrives
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c1_req", {31'b0, mem_req}, 32'd1);
    checkOutput("lock_c1_addr", mem_addr, IADDR);
    checkOutput("lock_c1_ok", {31'b0, inst_addr_ok}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c2_addr", mem_addr, IADDR);
    checkOutput("lock_c2_wr", {31'b0, mem_wr}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c3_addr", mem_addr, IADDR);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_rel_inst_ok", {31'b0, inst_addr_ok}, 32'd1);
    checkOutput("lock_rel_data_ok", {31'b0, data_addr_ok}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("after_lock_data_ok", {31'b0, data_addr_ok}, 32'd1);
    checkOutput("after_lock_addr", mem_addr, DADDR);
    acceptOne(1'b0);

    // In-order responses: inst, data, inst
    returnOne(1'b0, 32'h0000_0011);
    returnOne(1'b1, 32'h0000_0022);
    returnOne(1'b0, 32'h0000_0033);

    // Fill to DEPTH, stall while full, free one slot, mixed owners across wrap
    acceptOne(1'b1);
    acceptOne(1'b0);
    acceptOne(1'b1);
    acceptOne(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("full_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("full_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044);
    checkOutput("full_pop_req", {31'b0, mem_req}, 32'd0);
    checkOutput("full_pop_dok", {31'b0, data_data_ok}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("refill_req", {31'b0, mem_req}, 32'd1);
    checkOutput("refill_ok", {31'b0, inst_addr_ok}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0055);
    checkOutput("full2_req", {31'b0, mem_req}, 32'd0);
    checkOutput("full2_iok", {31'b0, inst_data_ok}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0066);
    checkOutput("pushpop_aok", {31'b0, data_addr_ok}, 32'd1);
    checkOutput("pushpop_dok", {31'b0, data_data_ok}, 32'd1);
    returnOne(1'b0, 32'h0000_0077);
    returnOne(1'b0, 32'h0000_0088);
    returnOne(1'b1, 32'h0000_0099);
    acceptOne(1'b1);
    returnOne(1'b1, 32'h0000_00A1);
    acceptOne(1'b0);
    returnOne(1'b0, 32'h0000_00A2);
    acceptOne(1'b1);
    returnOne(1'b1, 32'h0000_00A3);
    acceptOne(1'b0);
    returnOne(1'b0, 32'h0000_00A4);

    // Empty FIFO response is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00EE);
    checkOutput("empty_dok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);

    // Reset with two outstanding entries discards them
    acceptOne(1'b0);
    acceptOne(1'b1);
    @(negedge clk);
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst2_mem_req", {31'b0, mem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00FF);
    checkOutput("rst2_dok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
    acceptOne(1'b1);
    returnOne(1'b1, 32'h0000_0123);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of outstanding accepted requests tracked (power of 2, 2..8).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port inst_req  input  1  instruction fetch request (read-only requester).
REQ-005 The block SHALL have port inst_size  input  2  fetch size.
REQ-006 The block SHALL have port inst_addr  input  32  fetch physical address.
REQ-007 The block SHALL have port inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port inst_data_ok  output  1  fetch data returned this cycle.
REQ-009 The block SHALL have port inst_rdata  output  32  fetch data.
REQ-010 The block SHALL have port data_req  input  1  load/store request.
REQ-011 The block SHALL have port data_wr  input  1  1 = store.
REQ-012 The block SHALL have port data_size  input  2  access size.
REQ-013 The block SHALL have port data_wstrb  input  4  byte strobes.
REQ-014 The block SHALL have port data_addr  input  32  physical address.
REQ-015 The block SHALL have port data_wdata  input  32  store data.
REQ-016 The block SHALL have port data_addr_ok  output  1  load/store accepted this cycle.
REQ-017 The block SHALL have port data_data_ok  output  1  load data / store completion this cycle.
REQ-018 The block SHALL have port data_rdata  output  32  load data.
REQ-019 The block SHALL have ports mem_req, mem_wr (1), mem_size (2), mem_wstrb (4), mem_addr, mem_wdata (32), all outputs: shared memory request fields.
REQ-020 The block SHALL have ports mem_addr_ok, mem_data_ok (1), mem_rdata (32), all inputs: shared memory handshake and read data.

Function
REQ-021 Arbitration SHALL be fixed priority: data over inst when both request and no lock is held.
REQ-022 A lock register SHALL capture the winner when mem_req=1 and mem_addr_ok=0; while locked, the locked owner keeps the grant regardless of the other requester; the lock clears on mem_addr_ok or when the locked owner drops its req.
REQ-023 mem_req SHALL be (granted requester's req) AND NOT fifo_full; mem_* fields SHALL mux from the grantee; inst grant forces mem_wr=0, mem_wstrb=0, mem_wdata=0.
REQ-024 inst_addr_ok / data_addr_ok SHALL equal mem_addr_ok AND mem_req AND (grant is that requester); never both high.
REQ-025 An owner FIFO (DEPTH entries, 1 bit: 0 = inst, 1 = data) SHALL push the grantee on mem_req AND mem_addr_ok and pop on mem_data_ok when not empty.
REQ-026 mem_data_ok SHALL route to the head owner's data_ok in the same cycle (combinational); mem_rdata SHALL drive both inst_rdata and data_rdata unmodified.
REQ-027 Responses SHALL be in-order; the memory never asserts data_ok in the same cycle as the matching addr_ok.
REQ-028 Simultaneous push and pop SHALL advance both pointers, count unchanged; pointers wrap modulo DEPTH.
REQ-029 Full (count = DEPTH): mem_req=0, both addr_ok=0; a pop in that cycle frees a slot for the next cycle only.
REQ-030 Empty plus mem_data_ok: protocol error; no pop, inst_data_ok=data_data_ok=0, state unchanged.
REQ-031 Latency: zero added cycles on both request and response paths.

Reset
REQ-032 On reset=1 at posedge: FIFO pointers/count=0, lock=0; resulting outputs mem_req=0 unless a requester is high, all addr_ok/data_ok=0 absent memory handshake.
REQ-033 Reset mid-transaction SHALL discard all outstanding owner entries; later mem_data_ok with empty FIFO follows REQ-030.

Verification
REQ-034 inst_req and data_req both high with mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr; next cycle inst accepted.
REQ-035 inst_req alone, mem_addr_ok=0 for 3 cycles while data_req rises in cycle 2 -> grant stays inst until addr_ok; data accepted in the following cycle.
REQ-036 Accept inst, data, inst; return 3 mem_data_ok with rdata 0x11,0x22,0x33 -> inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
REQ-037 4 accepts, no returns (DEPTH=4) -> mem_req=0 with req held; one mem_data_ok -> mem_req reasserts next cycle; pointer wrap verified over 10 transactions.
REQ-038 mem_data_ok with FIFO empty, and reset with 2 outstanding -> no data_ok pulses, count stays 0.
